// File: rtl/keccak_pkg.sv
// Shared Keccak sizing, squeeze FSM encoding and rate-lane extraction helper.
// Squeeze-side XOF support in keccak_squeeze_unit is enabled by KECCAK_SQUEEZE_XOF_EN.
package keccak_pkg;

  localparam int ROW_SIZE   = 5;
  localparam int COL_SIZE   = 5;
  localparam int LANE_SIZE  = 64;
  localparam int DWIDTH     = 256;
  localparam int KEEP_WIDTH = DWIDTH / 8;
  localparam int RATE_WIDTH = 11;

  localparam int BYTES_PER_LANE = 8;
  localparam int MAX_RATE_LANES = 21;
  localparam int BEAT_LANES     = 4;

  // Byte offset inside a rate block (max 168) and byte count of one beat (max 32).
  localparam int OFF_WIDTH = 8;
  localparam int NB_WIDTH  = 6;

  typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
  typedef logic [MAX_RATE_LANES-1:0][LANE_SIZE-1:0]          rate_lanes_t;

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_EMIT      = 2'd1,
    SQ_WAIT_PERM = 2'd2
  } squeeze_state_e;

  // Linear lane L lives at state[L % 5][L / 5].
  function automatic rate_lanes_t extract_rate_lanes(input state_t s);
    rate_lanes_t r;
    r = '0;
    for (int l = 0; l < MAX_RATE_LANES; l++) begin
      r[l] = s[l % ROW_SIZE][l / ROW_SIZE];
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_squeeze_select.sv
// Combinational beat former: picks four consecutive rate lanes at a byte offset and
// zeroes/masks bytes at index n and above. Shared by both builds (KECCAK_SQUEEZE_XOF_EN agnostic).
module keccak_squeeze_select
  import keccak_pkg::*;
(
  input  rate_lanes_t           i_lanes,
  input  logic [OFF_WIDTH-1:0]  i_offset,
  input  logic [NB_WIDTH-1:0]   i_n,
  output logic [DWIDTH-1:0]     o_tdata,
  output logic [KEEP_WIDTH-1:0] o_tkeep
);

  logic [4:0]                  w_base;
  logic                        w_unused_off;
  logic [BEAT_LANES-1:0][5:0]  w_idx;
  logic [DWIDTH-1:0]           w_raw;

  // Offsets are lane aligned, so the low three bits never carry information.
  assign w_base       = i_offset[OFF_WIDTH-1:3];
  assign w_unused_off = ^i_offset[2:0];

  always_comb begin
    w_idx = '0;
    w_raw = '0;
    for (int k = 0; k < BEAT_LANES; k++) begin
      w_idx[k] = {1'b0, w_base} + 6'(k);
      if (w_idx[k] < 6'(MAX_RATE_LANES)) begin
        w_raw[k*LANE_SIZE +: LANE_SIZE] = i_lanes[w_idx[k][4:0]];
      end
    end
  end

  always_comb begin
    o_tkeep = '0;
    o_tdata = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      o_tkeep[b] = (NB_WIDTH'(b) < i_n);
      o_tdata[b*8 +: 8] = o_tkeep[b] ? w_raw[b*8 +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/keccak_squeeze_unit.sv
// Keccak squeeze engine: streams rate bytes of a state snapshot as masked 256-bit beats,
// requesting permutations between rate blocks. Optional XOF/stop support: KECCAK_SQUEEZE_XOF_EN.
module keccak_squeeze_unit
  import keccak_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic [LEN_WIDTH-1:0]  out_len_i,
  input  state_t                state_array_i,
  output logic                  perm_req_o,
  input  logic                  perm_done_i,
  input  logic                  stop_i,
  output logic [DWIDTH-1:0]     tdata_o,
  output logic [KEEP_WIDTH-1:0] tkeep_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic                  busy_o,
  output logic                  done_o
);

  squeeze_state_e         r_state;
  rate_lanes_t            r_lanes;
  logic [OFF_WIDTH-1:0]   r_rate_bytes;
  logic [OFF_WIDTH-1:0]   r_offset;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic                   r_perm_req;
  logic                   r_done;

  logic [OFF_WIDTH-1:0]   w_avail;
  logic [NB_WIDTH-1:0]    w_n_rate;
  logic [NB_WIDTH-1:0]    w_n;
  logic [OFF_WIDTH-1:0]   w_off_next;
  logic                   w_last_beat;
  logic                   w_emit;
  logic                   w_xof;
  logic                   w_stop_now;
  logic [DWIDTH-1:0]      w_sel_data;
  logic [KEEP_WIDTH-1:0]  w_sel_keep;
  logic                   w_unused;

`ifdef KECCAK_SQUEEZE_XOF_EN
  logic r_xof;
  logic r_stop_pend;

  assign w_xof      = r_xof;
  assign w_stop_now = r_stop_pend | stop_i;
  assign w_unused   = ^{state_array_i[1][4], state_array_i[2][4], state_array_i[3][4],
                        state_array_i[4][4], rate_i[2:0]};
`else
  assign w_xof      = 1'b0;
  assign w_stop_now = 1'b0;
  assign w_unused   = ^{state_array_i[1][4], state_array_i[2][4], state_array_i[3][4],
                        state_array_i[4][4], rate_i[2:0], stop_i};
`endif

  assign w_avail = r_rate_bytes - r_offset;

  // Beat size: capped by beat width, what is left of the rate block, and (fixed-length) the request.
  always_comb begin
    w_n_rate = (w_avail > OFF_WIDTH'(KEEP_WIDTH)) ? NB_WIDTH'(KEEP_WIDTH) : w_avail[NB_WIDTH-1:0];
    w_n      = w_n_rate;
    if (!w_xof && (r_remaining < LEN_WIDTH'(w_n_rate))) begin
      w_n = r_remaining[NB_WIDTH-1:0];
    end
  end

  assign w_off_next  = r_offset + OFF_WIDTH'(w_n);
  assign w_last_beat = !w_xof && (r_remaining == LEN_WIDTH'(w_n));
  assign w_emit      = (r_state == SQ_EMIT);

  keccak_squeeze_select u_select (
    .i_lanes  (r_lanes),
    .i_offset (r_offset),
    .i_n      (w_n),
    .o_tdata  (w_sel_data),
    .o_tkeep  (w_sel_keep)
  );

  assign tvalid_o   = w_emit;
  assign tdata_o    = w_emit ? w_sel_data : '0;
  assign tkeep_o    = w_emit ? w_sel_keep : '0;
  assign tlast_o    = w_emit & w_last_beat;
  assign busy_o     = (r_state != SQ_IDLE);
  assign perm_req_o = r_perm_req;
  assign done_o     = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SQ_IDLE;
      r_lanes      <= '0;
      r_rate_bytes <= '0;
      r_offset     <= '0;
      r_remaining  <= '0;
      r_perm_req   <= 1'b0;
      r_done       <= 1'b0;
`ifdef KECCAK_SQUEEZE_XOF_EN
      r_xof        <= 1'b0;
      r_stop_pend  <= 1'b0;
`endif
    end else begin
      r_perm_req <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        SQ_IDLE: begin
          if (start_i) begin
            r_lanes      <= extract_rate_lanes(state_array_i);
            r_rate_bytes <= rate_i[RATE_WIDTH-1:3];
            r_remaining  <= out_len_i;
            r_offset     <= '0;
`ifdef KECCAK_SQUEEZE_XOF_EN
            r_xof        <= (out_len_i == '0);
            r_stop_pend  <= 1'b0;
            r_state      <= SQ_EMIT;
`else
            if (out_len_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= SQ_EMIT;
            end
`endif
          end
        end

        SQ_EMIT: begin
`ifdef KECCAK_SQUEEZE_XOF_EN
          if (stop_i) begin
            r_stop_pend <= 1'b1;
          end
`endif
          if (tready_i) begin
            r_offset    <= w_off_next;
            r_remaining <= r_remaining - LEN_WIDTH'(w_n);
            // Completion wins over block exhaustion: out_len == rate_bytes ends without a permute.
            if (w_last_beat || w_stop_now) begin
              r_state <= SQ_IDLE;
              r_done  <= 1'b1;
            end else if (w_off_next == r_rate_bytes) begin
              r_state    <= SQ_WAIT_PERM;
              r_perm_req <= 1'b1;
            end
          end
        end

        SQ_WAIT_PERM: begin
          if (w_stop_now) begin
            r_state <= SQ_IDLE;
            r_done  <= 1'b1;
          end else if (perm_done_i) begin
            r_lanes  <= extract_rate_lanes(state_array_i);
            r_offset <= '0;
            r_state  <= SQ_EMIT;
          end
        end

        default: r_state <= SQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Self-checking bench for keccak_squeeze_unit: vector table with a byte-stream scoreboard,
// plus reset-abort and (when KECCAK_SQUEEZE_XOF_EN is defined) XOF stop sequences.
module tb_keccak_squeeze_unit;
  import keccak_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic [RATE_WIDTH-1:0] rate_i = '0;
  logic [15:0]           out_len_i = '0;
  state_t                state_array_i = '0;
  logic                  perm_req_o;
  logic                  perm_done_i = 1'b0;
  logic                  stop_i = 1'b0;
  logic [DWIDTH-1:0]     tdata_o;
  logic [KEEP_WIDTH-1:0] tkeep_o;
  logic                  tvalid_o;
  logic                  tready_i = 1'b0;
  logic                  tlast_o;
  logic                  busy_o;
  logic                  done_o;

  keccak_squeeze_unit #(.LEN_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .rate_i        (rate_i),
    .out_len_i     (out_len_i),
    .state_array_i (state_array_i),
    .perm_req_o    (perm_req_o),
    .perm_done_i   (perm_done_i),
    .stop_i        (stop_i),
    .tdata_o       (tdata_o),
    .tkeep_o       (tkeep_o),
    .tvalid_o      (tvalid_o),
    .tready_i      (tready_i),
    .tlast_o       (tlast_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rate;
    int len;
    int stall_beat;
    int stall_cyc;
    int exp_beats;
    int exp_perms;
  } vec_t;

  typedef struct {
    logic [DWIDTH-1:0]     d;
    logic [KEEP_WIDTH-1:0] k;
    logic                  l;
  } beat_t;

  int     checks = 0;
  int     errors = 0;
  beat_t  exp_q[$];
  vec_t   vecs[$];
  state_t st[4];

  task automatic check(input string nm, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Rate byte j of a state: byte (j % 8) of lane j / 8, lane L at state[L % 5][L / 5].
  function automatic logic [7:0] rbyte(input state_t s, input int j);
    int l;
    l = j / 8;
    return s[l % 5][l / 5][(j % 8)*8 +: 8];
  endfunction

  function automatic beat_t make_beat(input state_t s, input int off, input int n, input bit last);
    beat_t b;
    b.d = '0;
    b.k = '0;
    for (int j = 0; j < n; j++) begin
      b.d[j*8 +: 8] = rbyte(s, off + j);
      b.k[j] = 1'b1;
    end
    b.l = last;
    return b;
  endfunction

  task automatic randomize_states();
    for (int i = 0; i < 4; i++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          st[i][x][y] = {$urandom, $urandom};
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rb, rem, off, blk, n;
    int beats, perms, pd_cd, stall_left, cnt;
    bit fin, held;
    beat_t e;
    logic [DWIDTH-1:0] hd;
    logic [KEEP_WIDTH-1:0] hk;
    logic hl;
    string tag;

    tag = $sformatf("v%0d", idx);
    randomize_states();
    exp_q.delete();
    rb = v.rate / 8; rem = v.len; off = 0; blk = 0;
    while (rem > 0) begin
      n = 32;
      if (rb - off < n) n = rb - off;
      if (rem < n) n = rem;
      exp_q.push_back(make_beat(st[blk & 3], off, n, n == rem));
      off += n; rem -= n;
      if (rem > 0 && off == rb) begin blk++; off = 0; end
    end

    @(negedge clk);
    rate_i = v.rate[RATE_WIDTH-1:0]; out_len_i = v.len[15:0];
    state_array_i = st[0]; start_i = 1'b1; tready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    beats = 0; perms = 0; pd_cd = 0; stall_left = v.stall_cyc;
    cnt = 0; fin = 0; held = 0; hd = '0; hk = '0; hl = 1'b0;
    while (!fin && cnt < 2000) begin
      perm_done_i = 1'b0;
      if (pd_cd > 0) begin
        pd_cd--;
        if (pd_cd == 0) begin perm_done_i = 1'b1; state_array_i = st[perms & 3]; end
      end
      if (perm_req_o) begin perms++; pd_cd = 3; end
      tready_i = !(beats == v.stall_beat && stall_left > 0);
      if (tvalid_o) begin
        if (held) begin
          check({tag, "_hold_data"}, tdata_o, hd);
          check({tag, "_hold_keep"}, DWIDTH'(tkeep_o), DWIDTH'(hk));
          check({tag, "_hold_last"}, DWIDTH'(tlast_o), DWIDTH'(hl));
        end
        if (tready_i) begin
          held = 0;
          if (exp_q.size() == 0) begin
            check({tag, "_extra_beat"}, 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("%s_b%0d_data", tag, beats), tdata_o, e.d);
            check($sformatf("%s_b%0d_keep", tag, beats), DWIDTH'(tkeep_o), DWIDTH'(e.k));
            check($sformatf("%s_b%0d_last", tag, beats), DWIDTH'(tlast_o), DWIDTH'(e.l));
          end
          beats++;
        end else begin
          if (!held) begin hd = tdata_o; hk = tkeep_o; hl = tlast_o; end
          held = 1;
          stall_left--;
        end
      end
      if (done_o) fin = 1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    perm_done_i = 1'b0;
    check({tag, "_done_seen"}, DWIDTH'(fin), 1);
    check({tag, "_beats"}, beats, v.exp_beats);
    check({tag, "_perms"}, perms, v.exp_perms);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_end"}, DWIDTH'(busy_o), 0);
    check({tag, "_tvalid_end"}, DWIDTH'(tvalid_o), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, DWIDTH'(done_o), 0);
  endtask

  task automatic reset_in_wait_perm();
    int cnt;
    bit seen;
    randomize_states();
    @(negedge clk);
    rate_i = 11'd1344; out_len_i = 16'd400; state_array_i = st[0];
    start_i = 1'b1; tready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cnt = 0; seen = 0;
    while (!seen && cnt < 100) begin
      if (perm_req_o) seen = 1;
      else begin @(negedge clk); cnt++; end
    end
    check("rst_perm_req_seen", DWIDTH'(seen), 1);
    check("rst_wait_busy", DWIDTH'(busy_o), 1);
    rst = 1'b1;
    #1;
    check("rst_abort_busy", DWIDTH'(busy_o), 0);
    check("rst_abort_tvalid", DWIDTH'(tvalid_o), 0);
    check("rst_abort_perm_req", DWIDTH'(perm_req_o), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    perm_done_i = 1'b1; state_array_i = st[1];
    @(negedge clk);
    perm_done_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rst_after_c%0d", i),
            DWIDTH'({tvalid_o, busy_o, done_o, perm_req_o, tlast_o, |tkeep_o, |tdata_o}), 0);
      @(negedge clk);
    end
  endtask

`ifdef KECCAK_SQUEEZE_XOF_EN
  task automatic xof_stop();
    beat_t e;
    randomize_states();
    @(negedge clk);
    rate_i = 11'd1344; out_len_i = 16'd0; state_array_i = st[0];
    start_i = 1'b1; tready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      e = make_beat(st[0], 32*b, 32, 1'b0);
      check($sformatf("xof_b%0d_valid", b), DWIDTH'(tvalid_o), 1);
      check($sformatf("xof_b%0d_data", b), tdata_o, e.d);
      check($sformatf("xof_b%0d_last", b), DWIDTH'(tlast_o), 0);
      @(negedge clk);
    end
    tready_i = 1'b0; stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    e = make_beat(st[0], 64, 32, 1'b0);
    check("xof_held_valid", DWIDTH'(tvalid_o), 1);
    check("xof_held_data", tdata_o, e.d);
    check("xof_held_last", DWIDTH'(tlast_o), 0);
    tready_i = 1'b1;
    @(negedge clk);
    check("xof_stop_done", DWIDTH'(done_o), 1);
    check("xof_stop_tvalid", DWIDTH'(tvalid_o), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("xof_quiet_c%0d", i), DWIDTH'({tvalid_o, busy_o, done_o}), 0);
    end
  endtask
`endif

  initial begin
    vec_t v;
    v = '{1088,  32, -1, 0,  1, 0}; vecs.push_back(v);
    v = '{1344, 200, -1, 0,  7, 1}; vecs.push_back(v);
    v = '{ 576,  20, -1, 0,  1, 0}; vecs.push_back(v);
    v = '{1088, 136, -1, 0,  5, 0}; vecs.push_back(v);
    v = '{1344, 200,  2, 5,  7, 1}; vecs.push_back(v);
    v = '{1152, 300, -1, 0, 11, 2}; vecs.push_back(v);
    v = '{ 832,  50,  1, 3,  2, 0}; vecs.push_back(v);
`ifndef KECCAK_SQUEEZE_XOF_EN
    v = '{ 832,   0, -1, 0,  0, 0}; vecs.push_back(v);
`endif

    repeat (3) @(negedge clk);
    check("reset_tvalid", DWIDTH'(tvalid_o), 0);
    check("reset_busy", DWIDTH'(busy_o), 0);
    check("reset_done", DWIDTH'(done_o), 0);
    check("reset_perm_req", DWIDTH'(perm_req_o), 0);
    check("reset_tlast", DWIDTH'(tlast_o), 0);
    check("reset_tkeep", DWIDTH'(tkeep_o), 0);
    check("reset_tdata", tdata_o, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    reset_in_wait_perm();
`ifdef KECCAK_SQUEEZE_XOF_EN
    xof_stop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
